// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer so that
// back-to-back words stream out with no idle cycle between them.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               sout_q, sout_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               accept;

  // Bit currently presented by a shifter value, honouring the bit order.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (LSB_FIRST) begin
      return v[0];
    end else begin
      return v[WIDTH-1];
    end
  endfunction

  // Shifter contents after the presented bit has been consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    if (LSB_FIRST) begin
      return v >> 1;
    end else begin
      return v << 1;
    end
  endfunction

  assign accept = load_valid && ready_q;

  // Next-state logic for the FSM, shifter, counter and holding buffer.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          // Word ends this edge: refill from the buffer, bypass din, or idle.
          if (buf_full_q) begin
            shreg_d    = buf_q;
            cnt_d      = CNT_LAST;
            buf_full_d = 1'b0;
          end else if (accept) begin
            shreg_d = din;
            cnt_d   = CNT_LAST;
          end else begin
            shreg_d = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = IDLE;
          end
        end else begin
          shreg_d = advance(shreg_q);
          cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (accept) begin
            buf_d      = din;
            buf_full_d = 1'b1;
          end else begin
            buf_full_d = buf_full_q;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        shreg_d    = {WIDTH{1'b0}};
        cnt_d      = {CNT_W{1'b0}};
        buf_full_d = 1'b0;
      end
    endcase
  end

  // Output values derived from the upcoming state so every output is a flop.
  always_comb begin
    sout_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (state_d == SHIFT) begin
      sout_d  = out_bit(shreg_d);
      valid_d = 1'b1;
      done_d  = (cnt_d == {CNT_W{1'b0}});
    end else begin
      sout_d  = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
    ready_d = !buf_full_d;
    busy_d  = (state_d == SHIFT) || buf_full_d;
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= IDLE;
      shreg_q    <= {WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      buf_q      <= {WIDTH{1'b0}};
      buf_full_q <= 1'b0;
      sout_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      sout_q     <= sout_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign done       = done_q;
  assign load_ready = ready_q;
  assign busy       = busy_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It is the sending end of the serial bit lines that our serial-in shift registers capture. A WIDTH-bit word is accepted over a valid/ready handshake and shifted out one bit per clock, with a qualifying valid strobe. A one-word holding buffer lets back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, bits per word; legal range WIDTH >= 2
LSB_FIRST, 0, 0 = transmit MSB first; 1 = transmit LSB first

Ports:
clock  input  1  system clock; all state updates on posedge
clear  input  1  synchronous, active-high reset
din  input  WIDTH  parallel word to transmit
load_valid  input  1  din is valid
load_ready  output  1  block can accept a word this cycle
sout  output  1  serial data bit
sout_valid  output  1  sout carries a valid bit this cycle
busy  output  1  high in SHIFT state or while the buffer is full
done  output  1  one-cycle pulse, high during the last bit of each word

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high on clear, sampled at posedge clock.
- Reset (clear=1 at an edge): next cycle, and until clear drops:
  - Outputs: sout=0, sout_valid=0, load_ready=1, busy=0, done=0.
  - Internal: shifter=0, bit counter=0, buffer empty, state IDLE.
- Accept: a word is accepted at a posedge where load_valid && load_ready.
  - din is sampled only on accept.
  - load_valid while load_ready=0 is ignored; upstream holds din and load_valid.
- load_ready = !buf_full, driven from a register.
- FSM states: IDLE and SHIFT.
- IDLE:
  - On accept, din goes into the shifter and the state becomes SHIFT.
  - Latency is 1 cycle: the first bit appears on sout with sout_valid=1 in the cycle after the accepting edge.
- SHIFT:
  - One bit per cycle.
  - Bit order: din[WIDTH-1] down to din[0] when LSB_FIRST=0; din[0] up to din[WIDTH-1] when LSB_FIRST=1.
  - The counter counts remaining bits, WIDTH-1 down to 0. Its width is clog2(WIDTH).
  - sout_valid stays 1 for exactly WIDTH consecutive cycles per word.
  - done=1 only in the cycle presenting the last bit (counter==0).
  - An accept during SHIFT writes the word into the holding buffer (buf_full=1, so load_ready=0 next cycle).
- End of word (the edge that ends the counter==0 cycle):
  - Buffer full: the buffered word moves to the shifter and SHIFT continues with no gap. buf_full clears, so load_ready=1 next cycle.
  - Buffer empty and an accept at the same edge: bypass, with din loaded directly into the shifter and no gap.
  - Buffer empty and no accept: go to IDLE; sout_valid=0 and sout=0 next cycle.
- sout is 0 whenever sout_valid=0.
- busy = (state==SHIFT) || buf_full.
- clear mid-operation:
  - The in-flight word and the buffered word are discarded and never resumed.
  - Outputs take their reset values in the next cycle.
  - If clear and an accept coincide, clear wins and the word is dropped.
- No arithmetic beyond the counter decrement. The counter never wraps: it reloads to WIDTH-1 on each load.

Test Plan:
1. Reset: clear=1 for 2 cycles, with load_valid=1 and din=4'hF driven -> sout=0, sout_valid=0, load_ready=1, busy=0, done=0; no word is accepted.
2. Single word, MSB first (WIDTH=4, LSB_FIRST=0), din=4'b1011 accepted at edge T -> sout=1,0,1,1 in cycles T+1..T+4; sout_valid=1 only in T+1..T+4; done=1 only in T+4; IDLE with sout_valid=0 at T+5.
3. LSB first (LSB_FIRST=1), din=4'b1000 -> sout=0,0,0,1; done in the 4th bit cycle.
4. Streaming: load_valid held with 4'hA then 4'h5 -> 8 contiguous bits 1,0,1,0,0,1,0,1; sout_valid high 8 cycles; load_ready low from the cycle after the 4'h5 accept until the buffer-to-shifter transfer; done pulses twice, 4 cycles apart.
5. Bypass: 4'hC in flight with buffer empty, 4'h3 accepted exactly in the done cycle -> sout=1,1,0,0,0,0,1,1 with no gap; buffer never becomes full.
6. Abort: clear=1 during bit 2 of 4'h9 with 4'h6 buffered -> next cycle sout_valid=0, load_ready=1, busy=0; after clear drops, no bits of 4'h9 or 4'h6 ever appear.
